// File: rtl/tlight_monitor_pkg.sv
// rtl/tlight_monitor_pkg.sv - shared traffic-light types and monitor defaults
package tlight_package;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } tlight_control_t;

  typedef enum logic [2:0] {
    UNSYNC  = 3'd0,
    ALL_RED = 3'd1,
    WE_RDY  = 3'd2,
    WE_GO   = 3'd3,
    WE_STOP = 3'd4,
    NS_RDY  = 3'd5,
    NS_GO   = 3'd6,
    NS_STOP = 3'd7
  } tlight_mon_state_t;

  localparam int TLM_MIN_GREEN  = 10;
  localparam int TLM_MAX_GREEN  = 20;
  localparam int TLM_MAX_YELLOW = 4;

  function automatic logic is_go(tlight_mon_state_t s);
    return (s == WE_GO) || (s == NS_GO);
  endfunction

  function automatic logic is_stop(tlight_mon_state_t s);
    return (s == WE_STOP) || (s == NS_STOP);
  endfunction

  function automatic logic is_quiet(tlight_mon_state_t s);
    return (s == UNSYNC) || (s == ALL_RED);
  endfunction

endpackage

// File: rtl/tlight_monitor_if.sv
// rtl/tlight_monitor_if.sv - observed north-south / west-east light bus
interface tlight_monitor_if;
  import tlight_package::*;

  tlight_control_t ns;
  tlight_control_t we;

  modport master (output ns, output we);
  modport slave  (input ns, input we);

endinterface

// File: rtl/tlight_monitor_dwell_timer.sv
// rtl/tlight_monitor_dwell_timer.sv - saturating dwell counter with restart, hold-zero and limit checks
module tlight_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             hold_zero,
  input  logic [CNT_W-1:0] min_limit,
  input  logic [CNT_W-1:0] max_limit,
  output logic             too_short,
  output logic             too_long
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (hold_zero) begin
      count_next = '0;
    end else if (restart) begin
      count_next = CNT_W'(1);
    end else if (count != CNT_MAX) begin
      count_next = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // too_short judges the dwell just completed; too_long judges the value about to be stored
  assign too_short = (count < min_limit);
  assign too_long  = ({1'b0, count_next} == ({1'b0, max_limit} + {{CNT_W{1'b0}}, 1'b1}));

endmodule

// File: rtl/tlight_monitor.sv
// rtl/tlight_monitor.sv - passive traffic-light bus checker: phase decode, conflict, sequence and dwell errors
// Optional TLIGHT_MON_STATS_EN adds the cycles_done counter of legally completed STOP phases.
module tlight_monitor
  import tlight_package::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = TLM_MIN_GREEN,
  parameter int MAX_GREEN  = TLM_MAX_GREEN,
  parameter int MAX_YELLOW = TLM_MAX_YELLOW
) (
  input  logic              clock,
  input  logic              reset_n,
  tlight_monitor_if.slave   lights,
  input  logic              clear_err,
  output tlight_mon_state_t phase,
  output logic              synced,
  output logic              err_conflict,
  output logic              err_sequence,
  output logic              err_timing,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count
`ifdef TLIGHT_MON_STATS_EN
  ,
  output logic [15:0]       cycles_done
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G   = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] MAX_Y   = CNT_W'(MAX_YELLOW);

  tlight_control_t   ns;
  tlight_control_t   we;
  tlight_mon_state_t phase_next;
  logic              rr, ry, rg, yr, gr;
  logic              conflict;
  logic              seq_err;
  logic              timing_err;
  logic              err_event;
  logic              restart;
  logic              hold_zero;
  logic [CNT_W-1:0]  max_limit;
  logic              too_short;
  logic              too_long;

  assign ns = lights.ns;
  assign we = lights.we;

  assign rr = (ns == RED)    && (we == RED);
  assign ry = (ns == RED)    && (we == YELLOW);
  assign rg = (ns == RED)    && (we == GREEN);
  assign yr = (ns == YELLOW) && (we == RED);
  assign gr = (ns == GREEN)  && (we == RED);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase <= UNSYNC;
    end else begin
      phase <= phase_next;
    end
  end

  always_comb begin
    phase_next = phase;
    conflict   = 1'b0;
    seq_err    = 1'b0;
    if ((ns != RED) && (we != RED)) begin
      conflict   = 1'b1;
      phase_next = UNSYNC;
    end else begin
      // each synced state accepts its own pair (hold) or its legal successors' pairs
      case (phase)
        UNSYNC:  if (rr) phase_next = ALL_RED;
        ALL_RED: begin
          if (ry)       phase_next = WE_RDY;
          else if (yr)  phase_next = NS_RDY;
          else if (!rr) seq_err    = 1'b1;
        end
        WE_RDY: begin
          if (rg)       phase_next = WE_GO;
          else if (!ry) seq_err    = 1'b1;
        end
        WE_GO: begin
          if (ry)       phase_next = WE_STOP;
          else if (!rg) seq_err    = 1'b1;
        end
        WE_STOP: begin
          if (rr)       phase_next = ALL_RED;
          else if (yr)  phase_next = NS_RDY;
          else if (!ry) seq_err    = 1'b1;
        end
        NS_RDY: begin
          if (gr)       phase_next = NS_GO;
          else if (!yr) seq_err    = 1'b1;
        end
        NS_GO: begin
          if (yr)       phase_next = NS_STOP;
          else if (!gr) seq_err    = 1'b1;
        end
        NS_STOP: begin
          if (rr)       phase_next = ALL_RED;
          else if (ry)  phase_next = WE_RDY;
          else if (!yr) seq_err    = 1'b1;
        end
        default: phase_next = UNSYNC;
      endcase
      if (seq_err) phase_next = UNSYNC;
    end
  end

  assign restart   = (phase_next != phase);
  assign hold_zero = is_quiet(phase_next);
  assign max_limit = is_go(phase_next) ? MAX_G : MAX_Y;

  tlight_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clock    (clock),
    .reset_n  (reset_n),
    .restart  (restart),
    .hold_zero(hold_zero),
    .min_limit(MIN_G),
    .max_limit(max_limit),
    .too_short(too_short),
    .too_long (too_long)
  );

  // a conflict takes precedence over the dwell checks as well as the sequence check
  assign timing_err = !conflict &&
                      ((is_go(phase) && restart && too_short) || (too_long && !hold_zero));
  assign err_event  = conflict || seq_err || timing_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      synced       <= 1'b0;
      err_conflict <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
    end else begin
      synced    <= (phase_next != UNSYNC);
      err_pulse <= err_event;
      if (clear_err) begin
        err_conflict <= conflict;
        err_sequence <= seq_err;
        err_timing   <= timing_err;
        err_count    <= err_event ? CNT_W'(1) : '0;
      end else begin
        err_conflict <= err_conflict | conflict;
        err_sequence <= err_sequence | seq_err;
        err_timing   <= err_timing   | timing_err;
        if (err_event && (err_count != CNT_MAX)) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef TLIGHT_MON_STATS_EN
  logic stop_exit;

  assign stop_exit = is_stop(phase) && restart && !conflict && !seq_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cycles_done <= '0;
    end else begin
      cycles_done <= cycles_done + 16'(stop_exit);
    end
  end
`endif

endmodule

// File: tb/tb_tlight_monitor.sv
// tb/tb_tlight_monitor.sv - scoreboard bench for tlight_monitor (directed scenarios plus random light traffic)
module tb_tlight_monitor;
  import tlight_package::*;

  localparam int CNT_MAX = 255;
  localparam int MIN_G   = 10;
  localparam int MAX_G   = 20;
  localparam int MAX_Y   = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear_err = 1'b0;

  tlight_monitor_if lights();

  tlight_mon_state_t phase;
  logic              synced, err_conflict, err_sequence, err_timing, err_pulse;
  logic [7:0]        err_count;
`ifdef TLIGHT_MON_STATS_EN
  logic [15:0]       cycles_done;
`endif

  tlight_monitor #(
    .CNT_W(8), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .MAX_YELLOW(MAX_Y)
  ) dut (
    .clock(clock), .reset_n(reset_n), .lights(lights), .clear_err(clear_err),
    .phase(phase), .synced(synced), .err_conflict(err_conflict),
    .err_sequence(err_sequence), .err_timing(err_timing), .err_pulse(err_pulse),
    .err_count(err_count)
`ifdef TLIGHT_MON_STATS_EN
    , .cycles_done(cycles_done)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    tlight_mon_state_t ph;
    logic sy, conf, seq, tim, pulse;
    int   count;
    int   cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference: every legal (from, to) phase step; a step is matched by the colour pair of 'to'
  tlight_mon_state_t leg_from [10] = '{ALL_RED, ALL_RED, WE_RDY, WE_GO, WE_STOP, WE_STOP,
                                       NS_RDY, NS_GO, NS_STOP, NS_STOP};
  tlight_mon_state_t leg_to   [10] = '{WE_RDY, NS_RDY, WE_GO, WE_STOP, ALL_RED, NS_RDY,
                                       NS_GO, NS_STOP, ALL_RED, WE_RDY};

  tlight_mon_state_t m_phase = UNSYNC;
  int m_dwell = 0, m_count = 0, m_cycles = 0;
  bit m_conf = 0, m_seq = 0, m_tim = 0, m_pulse = 0;

  function automatic logic [3:0] colours(tlight_mon_state_t s);
    case (s)
      ALL_RED:          return {RED, RED};
      WE_RDY, WE_STOP:  return {RED, YELLOW};
      WE_GO:            return {RED, GREEN};
      NS_RDY, NS_STOP:  return {YELLOW, RED};
      NS_GO:            return {GREEN, RED};
      default:          return 4'hF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input tlight_control_t n, input tlight_control_t w,
                            input logic clr, input logic rn);
    tlight_mon_state_t nxt;
    int  nd, lim;
    bit  conf, seq, tim, stop_ok;
    exp_t e;
    if (!rn) begin
      m_phase = UNSYNC; m_dwell = 0; m_count = 0; m_cycles = 0;
      m_conf = 0; m_seq = 0; m_tim = 0; m_pulse = 0;
    end else begin
      conf = (n != RED) && (w != RED);
      seq = 0; tim = 0; stop_ok = 0; nxt = m_phase;
      if (conf) nxt = UNSYNC;
      else if (m_phase == UNSYNC) begin
        if (n == RED && w == RED) nxt = ALL_RED;
      end else if ({n, w} != colours(m_phase)) begin
        seq = 1; nxt = UNSYNC;
        for (int i = 0; i < 10; i++)
          if (leg_from[i] == m_phase && colours(leg_to[i]) == {n, w}) begin
            seq = 0; nxt = leg_to[i];
          end
        stop_ok = !seq && (m_phase == WE_STOP || m_phase == NS_STOP);
      end
      if (nxt == UNSYNC || nxt == ALL_RED) nd = 0;
      else if (nxt != m_phase)             nd = 1;
      else                                 nd = (m_dwell < CNT_MAX) ? m_dwell + 1 : CNT_MAX;
      if (!conf && m_phase != UNSYNC) begin
        if ((m_phase == WE_GO || m_phase == NS_GO) && nxt != m_phase && m_dwell < MIN_G) tim = 1;
        lim = (nxt == WE_GO || nxt == NS_GO) ? MAX_G : MAX_Y;
        if (nd != 0 && nd == lim + 1) tim = 1;
      end
      m_pulse = conf || seq || tim;
      if (clr) begin
        m_conf = conf; m_seq = seq; m_tim = tim; m_count = m_pulse ? 1 : 0;
      end else begin
        m_conf |= conf; m_seq |= seq; m_tim |= tim;
        if (m_pulse && m_count < CNT_MAX) m_count++;
      end
      if (stop_ok) m_cycles = (m_cycles + 1) % 65536;
      m_phase = nxt; m_dwell = nd;
    end
    e.ph = m_phase; e.sy = (m_phase != UNSYNC); e.conf = m_conf; e.seq = m_seq;
    e.tim = m_tim; e.pulse = m_pulse; e.count = m_count; e.cycles = m_cycles;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("phase", 32'(phase), 32'(e.ph));
        check("synced", 32'(synced), 32'(e.sy));
        check("err_conflict", 32'(err_conflict), 32'(e.conf));
        check("err_sequence", 32'(err_sequence), 32'(e.seq));
        check("err_timing", 32'(err_timing), 32'(e.tim));
        check("err_pulse", 32'(err_pulse), 32'(e.pulse));
        check("err_count", 32'(err_count), 32'(e.count));
`ifdef TLIGHT_MON_STATS_EN
        check("cycles_done", 32'(cycles_done), 32'(e.cycles));
`endif
      end
    end
  end

  task automatic cyc(input tlight_control_t n, input tlight_control_t w,
                     input logic clr, input logic rn);
    @(negedge clock);
    lights.ns = n; lights.we = w; clear_err = clr; reset_n = rn;
    model_step(n, w, clr, rn);
  endtask

  task automatic hold(input tlight_control_t n, input tlight_control_t w, input int k);
    for (int i = 0; i < k; i++) cyc(n, w, 1'b0, 1'b1);
  endtask

  task automatic rhold(input tlight_control_t n, input tlight_control_t w, input int k);
    for (int i = 0; i < k; i++) cyc(n, w, ($urandom_range(0, 19) == 0), 1'b1);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  int npulse, pulse_at, y1, g, y2;
  tlight_control_t rn_c, rw_c;

  initial begin
    lights.ns = RED; lights.we = RED;
    // 1: reset, legal WE cycle then legal NS cycle
    cyc(RED, RED, 1'b0, 1'b0); cyc(RED, RED, 1'b0, 1'b0);
    settle();
    check("reset_phase", 32'(phase), 32'(UNSYNC));
    check("reset_count", 32'(err_count), 0);
    hold(RED, RED, 1);
    hold(RED, YELLOW, 3); hold(RED, GREEN, 15); hold(RED, YELLOW, 3);
    hold(YELLOW, RED, 3); hold(GREEN, RED, 15); hold(YELLOW, RED, 3);
    hold(RED, RED, 1);
    settle();
    check("t1_synced", 32'(synced), 1);
    check("t1_errs", 32'({err_conflict, err_sequence, err_timing}), 0);
`ifdef TLIGHT_MON_STATS_EN
    check("t1_cycles_done", 32'(cycles_done), 2);
`endif
    // 2: conflict in WE_GO
    cyc(RED, RED, 1'b1, 1'b1);
    hold(RED, YELLOW, 2); hold(RED, GREEN, 12);
    hold(GREEN, GREEN, 1);
    settle();
    check("t2_conflict", 32'(err_conflict), 1);
    check("t2_pulse", 32'(err_pulse), 1);
    check("t2_count", 32'(err_count), 1);
    check("t2_phase", 32'(phase), 32'(UNSYNC));
    hold(RED, RED, 1);
    settle();
    check("t2_resync", 32'(phase), 32'(ALL_RED));
    // 3: ALL_RED straight to green
    cyc(RED, RED, 1'b1, 1'b1);
    hold(RED, GREEN, 1);
    settle();
    check("t3_sequence", 32'(err_sequence), 1);
    check("t3_count", 32'(err_count), 1);
    check("t3_phase", 32'(phase), 32'(UNSYNC));
    // 4a: green too short
    cyc(RED, RED, 1'b1, 1'b1);
    hold(RED, YELLOW, 2); hold(RED, GREEN, 9); hold(RED, YELLOW, 1);
    settle();
    check("t4a_timing", 32'(err_timing), 1);
    check("t4a_phase", 32'(phase), 32'(WE_STOP));
    hold(RED, YELLOW, 1);
    // 4b: yellow too long, flagged once on the fifth cycle
    cyc(RED, RED, 1'b1, 1'b1);
    npulse = 0; pulse_at = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(YELLOW, RED, 1'b0, 1'b1);
      settle();
      if (err_pulse === 1'b1) begin npulse++; pulse_at = k; end
    end
    check("t4b_pulses", 32'(npulse), 1);
    check("t4b_pulse_dwell", 32'(pulse_at), 5);
    // 5: saturation, then clear together with a new sequence error
    cyc(RED, RED, 1'b1, 1'b1);
    hold(GREEN, GREEN, 300);
    settle();
    check("t5_saturate", 32'(err_count), 255);
    hold(RED, RED, 1);
    cyc(RED, GREEN, 1'b1, 1'b1);
    settle();
    check("t5_clear_count", 32'(err_count), 1);
    check("t5_clear_seq", 32'(err_sequence), 1);
    check("t5_clear_conf", 32'(err_conflict), 0);
    // 6: reset mid NS_GO, no checks until R/R
    cyc(RED, RED, 1'b1, 1'b1);
    hold(YELLOW, RED, 3); hold(GREEN, RED, 5);
    cyc(GREEN, RED, 1'b0, 1'b0);
    settle();
    check("t6_phase", 32'(phase), 32'(UNSYNC));
    check("t6_flags", 32'({synced, err_conflict, err_sequence, err_timing, err_pulse}), 0);
    hold(GREEN, RED, 3); hold(RED, GREEN, 2);
    settle();
    check("t6_nocheck", 32'(err_count), 0);
    hold(RED, RED, 1);
    // random traffic with occasional glitches and clears
    for (int it = 0; it < 60; it++) begin
      y1 = $urandom_range(1, 6); g = $urandom_range(7, 23); y2 = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) rhold(RED, RED, $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) begin
        rhold(RED, YELLOW, y1); rhold(RED, GREEN, g); rhold(RED, YELLOW, y2);
      end else begin
        rhold(YELLOW, RED, y1); rhold(GREEN, RED, g); rhold(YELLOW, RED, y2);
      end
      if ($urandom_range(0, 4) == 0) begin
        rn_c = tlight_control_t'($urandom_range(0, 2));
        rw_c = tlight_control_t'($urandom_range(0, 2));
        rhold(rn_c, rw_c, 1);
      end
      if ($urandom_range(0, 29) == 0) cyc(RED, RED, 1'b0, 1'b0);
    end
    hold(RED, RED, 2);
    @(posedge clock);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
